// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, 64-set, one-word-line,
// write-through / no-write-allocate cache between the MEM stage and an
// SRAM controller. Read hits complete in the same cycle; misses and stores
// wait for sram_ready.
// Optional feature macro: CACHE_STATS_EN adds the saturating hit_count and
// miss_count outputs.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_re_en,
  output logic        sram_we_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, RD_MISS, WRITE} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_valid0, r_valid1, r_lru;
  logic [11:0] r_tag0  [0:63];
  logic [11:0] r_tag1  [0:63];
  logic [31:0] r_data0 [0:63];
  logic [31:0] r_data1 [0:63];
  logic [31:0] r_rdata;

  logic [5:0]  w_idx;
  logic [11:0] w_tag;
  logic        w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
  logic [31:0] w_hit_data, w_rdata;
  logic        w_rd_hit, w_fill, w_wr_upd, w_miss_start;
  logic        w_unused;

  assign w_idx        = address[7:2];
  assign w_tag        = address[19:8];
  assign w_unused     = ^{address[31:20], address[1:0]};
  assign sram_address = address[19:2];
  assign sram_wdata   = wdata;
  assign sram_re_en   = (r_state == RD_MISS);
  assign sram_we_en   = (r_state == WRITE);
  assign rdata        = w_rdata;

  assign w_hit0     = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_hit1     = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
  assign w_hit      = w_hit0 | w_hit1;
  assign w_hit_way  = w_hit1;
  assign w_hit_data = w_hit1 ? r_data1[w_idx] : r_data0[w_idx];
  // Fill empty ways first (way0 before way1), then the LRU-named way.
  assign w_victim   = !r_valid0[w_idx] ? 1'b0 :
                      !r_valid1[w_idx] ? 1'b1 : r_lru[w_idx];

  // Next state, ready/rdata and the array update strobes.
  always_comb begin
    w_next       = r_state;
    ready        = 1'b1;
    w_rdata      = r_rdata;
    w_rd_hit     = 1'b0;
    w_fill       = 1'b0;
    w_wr_upd     = 1'b0;
    w_miss_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (MEM_W_EN) begin           // store wins when both enables are set
          ready  = 1'b0;
          w_next = WRITE;
        end else if (MEM_R_EN) begin
          if (w_hit) begin
            w_rdata  = w_hit_data;
            w_rd_hit = 1'b1;
          end else begin
            ready        = 1'b0;
            w_next       = RD_MISS;
            w_miss_start = 1'b1;
          end
        end
      end
      RD_MISS: begin
        ready = sram_ready;
        if (sram_ready) begin
          w_rdata = sram_rdata;
          w_fill  = 1'b1;
          w_next  = IDLE;
        end
      end
      WRITE: begin
        ready = sram_ready;
        if (sram_ready) begin
          w_wr_upd = w_hit;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, valid, LRU and held read data; all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_hit) begin
        r_rdata        <= w_hit_data;
        r_lru[w_idx]   <= ~w_hit_way;
      end
      if (w_fill) begin
        r_rdata        <= sram_rdata;
        r_lru[w_idx]   <= ~w_victim;
        if (w_victim) r_valid1[w_idx] <= 1'b1;
        else          r_valid0[w_idx] <= 1'b1;
      end
      if (w_wr_upd) r_lru[w_idx] <= ~w_hit_way;
    end
  end

  // Tag/data storage is not reset; reset forces IDLE so no strobe fires.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (w_victim) begin
        r_tag1[w_idx]  <= w_tag;
        r_data1[w_idx] <= sram_rdata;
      end else begin
        r_tag0[w_idx]  <= w_tag;
        r_data0[w_idx] <= sram_rdata;
      end
    end
    if (w_wr_upd) begin
      if (w_hit_way) r_data1[w_idx] <= wdata;
      else           r_data0[w_idx] <= wdata;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating read hit / miss counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_rd_hit && hit_count != 16'hFFFF)      hit_count  <= hit_count + 16'd1;
      if (w_miss_start && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a per-set recency list plus a flat
// word memory predict hit/miss, latency, SRAM enables and read data.
module tb_cache_controller;
  logic        clk = 0, rst = 0;
  logic [31:0] address = 0, wdata = 0, rdata, sram_wdata, sram_rdata = 0;
  logic        MEM_R_EN = 0, MEM_W_EN = 0, ready, sram_re_en, sram_we_en;
  logic        sram_ready = 0;
  logic [17:0] sram_address;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_re_en(sram_re_en), .sram_we_en(sram_we_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each set is a recency list of up to two tags (index 0 = MRU).
  int          m_n [64];
  logic [11:0] m_t [64][2];
  logic [31:0] mem [logic [17:0]];
  logic [31:0] last_rd = 0;
  int          m_hits = 0, m_miss = 0;

  function automatic bit m_hit(logic [31:0] a);
    int s = int'(a[7:2]);
    for (int i = 0; i < m_n[s]; i++) if (m_t[s][i] == a[19:8]) return 1;
    return 0;
  endfunction

  function automatic void m_use(logic [31:0] a);
    int s = int'(a[7:2]);
    logic [11:0] t = a[19:8];
    if (m_n[s] > 0 && m_t[s][0] == t) return;
    if (m_n[s] == 2 && m_t[s][1] == t) begin
      m_t[s][1] = m_t[s][0]; m_t[s][0] = t; return;
    end
    m_t[s][1] = m_t[s][0]; m_t[s][0] = t;   // least recent drops off when full
    if (m_n[s] < 2) m_n[s]++;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_n[i] = 0;
    last_rd = 0; m_hits = 0; m_miss = 0;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    logic [17:0] k = a[19:2];
    if (mem.exists(k)) return mem[k];
    return {14'h2A5, k};
  endfunction

  // One request held until ready; SRAM answers on the lat-th enabled cycle.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input int lat);
    int en = 0, lowc = 0, cyc = 0;
    bit sre = 0, swe = 0, done = 0, hit;
    logic [31:0] rd = 0;
    hit = m_hit(a);
    address = a; wdata = d; MEM_W_EN = wr;
    MEM_R_EN = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!done && cyc < 64) begin
      #1;
      if (sram_re_en || sram_we_en) begin en++; sram_ready = (en >= lat); end
      else sram_ready = 1'($urandom_range(0, 1));
      sram_rdata = mem_rd(a);
      #1;
      if (cyc == 0) begin
        chk("sram_address", 32'(sram_address), 32'(a[19:2]));
        chk("sram_wdata", sram_wdata, d);
      end
      sre |= sram_re_en; swe |= sram_we_en;
      if (ready) begin done = 1; rd = rdata; end else lowc++;
      @(posedge clk); @(negedge clk); cyc++;
    end
    MEM_R_EN = 0; MEM_W_EN = 0; sram_ready = 0;
    if (!done) chk("timeout", 0, 1);
    chk("wait_cycles", lowc, (wr || !hit) ? lat : 0);
    chk("saw_re_en", 32'(sre), 32'(!wr && !hit));
    chk("saw_we_en", 32'(swe), 32'(wr));
    if (wr) begin
      mem[a[19:2]] = d;
      if (hit) m_use(a);
    end else begin
      chk("rdata", rd, mem_rd(a));
      last_rd = mem_rd(a);
      if (hit) m_hits++; else m_miss++;
      m_use(a);
    end
`ifdef CACHE_STATS_EN
    chk("hit_count", 32'(hit_count), m_hits);
    chk("miss_count", 32'(miss_count), m_miss);
`endif
  endtask

  task automatic idle_cyc();
    logic [31:0] r = $urandom;
    address = r; MEM_R_EN = 0; MEM_W_EN = 0;
    sram_ready = 1'($urandom_range(0, 1));
    #2;
    chk("idle_ready", 32'(ready), 1);
    chk("idle_rdata", rdata, last_rd);
    chk("idle_re_en", 32'(sram_re_en), 0);
    @(posedge clk); @(negedge clk);
    sram_ready = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    logic [11:0] t = 12'($urandom_range(0, 5));
    logic [5:0]  s = 6'($urandom_range(0, 3));
    return {r[31:20], t, s, 2'b00};
  endfunction

  initial begin
    logic [31:0] a;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(ready), 1);
    chk("reset_rdata", rdata, 0);
    chk("reset_re_en", 32'(sram_re_en), 0);
    chk("reset_we_en", 32'(sram_we_en), 0);
    @(negedge clk); rst = 1;
    @(negedge clk);

    // First load misses, repeat hits, store then hit, LRU eviction.
    access(0, 32'h400, 0, 4);
    access(0, 32'h400, 0, 4);
    access(1, 32'h400, 32'hDEADBEEF, 3);
    access(0, 32'h400, 0, 2);
    access(0, 32'h500, 0, 2);
    access(0, 32'h400, 0, 2);
    access(0, 32'h600, 0, 2);
    access(0, 32'h400, 0, 2);
    access(0, 32'h500, 0, 2);
    idle_cyc();

    for (int i = 0; i < 300; i++) begin
      a = rand_addr();
      if ($urandom_range(0, 3) == 0) access(1, a, $urandom, $urandom_range(1, 4));
      else                           access(0, a, $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 4) == 0) idle_cyc();
    end

    // Reset two cycles into a read miss abandons it and invalidates all.
    address = 32'h000ABC04; MEM_R_EN = 1; sram_ready = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("pre_reset_re_en", 32'(sram_re_en), 1);
    rst = 0;
    #1;
    chk("reset_drop_re_en", 32'(sram_re_en), 0);
    chk("reset_mid_rdata", rdata, 0);
    m_reset();
    @(negedge clk); rst = 1; MEM_R_EN = 0;
    @(negedge clk);
    access(0, 32'h400, 0, 3);
    access(0, 32'h000ABC04, 0, 2);
    for (int i = 0; i < 100; i++) begin
      a = rand_addr();
      access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  32  MEM-stage byte address (word-aligned).
- wdata  in  32  MEM-stage store data.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- rdata  out  32  load data to MEM stage.
- ready  out  1  request complete; pipeline freezes while 0.
- sram_address  out  18  word address to SRAM controller.
- sram_wdata  out  32  store data to SRAM controller.
- sram_re_en  out  1  SRAM read request.
- sram_we_en  out  1  SRAM write request.
- sram_rdata  in  32  SRAM read data.
- sram_ready  in  1  SRAM access complete.
- hit_count  out  16  read-hit counter (only with CACHE_STATS_EN).
- miss_count  out  16  read-miss counter (only with CACHE_STATS_EN).

Function
REQ-002 Organisation SHALL be 2-way set-associative, 64 sets, one 32-bit word per line; index = address[7:2], tag = address[19:8]; each way keeps valid bit, 12-bit tag, 32-bit data; one LRU bit per set naming the victim way.
REQ-003 sram_address SHALL equal address[19:2] and sram_wdata SHALL equal wdata, combinationally.
REQ-004 States: IDLE, RD_MISS, WRITE; sram_re_en = (state==RD_MISS); sram_we_en = (state==WRITE).
REQ-005 IDLE, no request: ready=1, state stays IDLE, rdata holds its last value.
REQ-006 IDLE, MEM_R_EN hit: rdata = hit-way data and ready=1 in the same cycle (zero wait); LRU[index] <= ~hit_way at the edge.
REQ-007 IDLE, MEM_R_EN miss: ready=0, next state RD_MISS.
REQ-008 RD_MISS: ready=0 while sram_ready=0; in the cycle sram_ready=1, rdata=sram_rdata and ready=1; at that edge fill victim (way0 if invalid, else way1 if invalid, else LRU[index]), set valid and tag, LRU[index] <= ~filled_way, next state IDLE.
REQ-009 IDLE, MEM_W_EN: ready=0, next state WRITE (write-through, no write-allocate).
REQ-010 WRITE: ready=0 while sram_ready=0; in the cycle sram_ready=1, ready=1; at that edge, if tag hits in a way, that way's data <= wdata and LRU[index] <= ~hit_way; misses leave arrays and LRU unchanged; next state IDLE.
REQ-011 MEM_R_EN and MEM_W_EN both high SHALL be treated as a store.
REQ-012 sram_ready SHALL be ignored in IDLE; address, wdata and enables are held stable by the pipeline while ready=0, and the block does not latch them.
REQ-013 Both ways hitting the same tag cannot occur; fills only happen on a miss.

Reset
REQ-014 rst low SHALL, asynchronously: state <= IDLE, all valid bits <= 0, all LRU bits <= 0, rdata <= 0, counters <= 0; sram_re_en, sram_we_en drop to 0 immediately.
REQ-015 Tag/data arrays SHALL NOT be reset.
REQ-016 Reset mid-RD_MISS or mid-WRITE SHALL abandon the access with no array update; after release a held request restarts from IDLE.

Configuration
REQ-017 With CACHE_STATS_EN defined, hit_count SHALL increment on each REQ-006 cycle and miss_count on each IDLE->RD_MISS transition, both saturating at 16'hFFFF; without it, both ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-018 After reset, load 0x00000400 with an SRAM model asserting sram_ready on the 4th cycle of an enable -> ready low 4 cycles, rdata=model data, miss_count=1.
REQ-019 Repeat load 0x00000400 -> ready=1 same cycle, rdata unchanged, sram_re_en never asserted, hit_count=1.
REQ-020 Store 0xDEADBEEF to 0x00000400 then load it -> sram_we_en high until sram_ready, then load hits returning 0xDEADBEEF.
REQ-021 Loads 0x400, 0x500, 0x400, 0x600 (same index 0) -> 0x600 evicts 0x500 way; subsequent 0x400 load hits, 0x500 load misses.
REQ-022 Assert rst low during RD_MISS cycle 2 -> sram_re_en=0 immediately; after release, load 0x400 misses (all valid bits cleared).
